reduce_sched: RTL and testbench

- Shares one 4-input reduction unit (bitwise AND or OR reduction) among NUM_REQ requesters.
- Round-robin arbitration; at most one operation accepted per cycle.
- Registered response with valid/ready backpressure.
- Sits between requester blocks and the reduction datapath; also keeps a wrapping transaction counter for status.

---
 rtl/reduce_pkg.sv | 15 +
 rtl/reduce_sched_if.sv | 32 +++
 rtl/reduce4_unit.sv | 15 +
 rtl/reduce_sched.sv | 123 ++++++++++++
 tb/tb_reduce_sched.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/reduce_pkg.sv
// Shared encodings and default widths for the reduce_sched slice.
package reduce_pkg;

  localparam int DEF_OPW  = 4;
  localparam int DEF_CNTW = 8;

  localparam logic OP_AND = 1'b0;
  localparam logic OP_OR  = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FULL = 1'b1
  } state_t;

endpackage

// File: rtl/reduce_sched_if.sv
// Request/response bundle between requesters and reduce_sched; master = requester/sink side.
interface reduce_sched_if
  import reduce_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2,
  parameter int OPW     = DEF_OPW,
  parameter int CNTW    = DEF_CNTW
);

  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ-1:0]     req_op;
  logic [NUM_REQ*OPW-1:0] req_data;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [IDW-1:0]         rsp_id;
  logic                   rsp_op;
  logic                   rsp_result;
  logic [CNTW-1:0]        txn_count;

  modport master (
    output req_valid, req_op, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_op, rsp_result, txn_count
  );

  modport slave (
    input  req_valid, req_op, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_op, rsp_result, txn_count
  );

endinterface

// File: rtl/reduce4_unit.sv
// Combinational AND/OR reduction of one operand vector.
// Latency: none; no flow control, purely combinational.
module reduce4_unit
  import reduce_pkg::*;
#(
  parameter int OPW = DEF_OPW
) (
  input  logic [OPW-1:0] data,
  input  logic           op,
  output logic           result
);

  assign result = (op == OP_OR) ? (|data) : (&data);

endmodule

// File: rtl/reduce_sched.sv
// Round-robin share of one reduction unit across NUM_REQ requesters, single-entry response slot.
// Latency: accept to rsp_valid one cycle; backpressure: rsp_ready=0 holds the slot and zeroes req_ready.
module reduce_sched
  import reduce_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2,
  parameter int OPW     = DEF_OPW,
  parameter int CNTW    = DEF_CNTW
) (
  input  logic         clk,
  input  logic         rst_n,
  reduce_sched_if.slave bus
);

  if (IDW < $clog2(NUM_REQ)) begin : g_bad_idw
    $error("reduce_sched: IDW is too narrow to index NUM_REQ requesters");
  end
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("reduce_sched: NUM_REQ must be in 2..8");
  end

  state_t             state_q;
  state_t             state_d;
  logic [IDW-1:0]     rr_ptr_q;
  logic [IDW-1:0]     grant_idx;
  logic               grant_any;
  logic [NUM_REQ-1:0] grant_oh;
  logic               slot_free;
  logic               accept;
  logic [OPW-1:0]     sel_data;
  logic               sel_op;
  logic               unit_result;
  logic [IDW-1:0]     rsp_id_q;
  logic               rsp_op_q;
  logic               rsp_result_q;
  logic [CNTW-1:0]    txn_q;

  // Two passes give the search order rr_ptr+1 .. NUM_REQ-1, then 0 .. rr_ptr.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_any && bus.req_valid[i] && (IDW'(i) > rr_ptr_q)) begin
        grant_any = 1'b1;
        grant_idx = IDW'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_any && bus.req_valid[i] && (IDW'(i) <= rr_ptr_q)) begin
        grant_any = 1'b1;
        grant_idx = IDW'(i);
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    sel_data = '0;
    sel_op   = OP_AND;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_any && (grant_idx == IDW'(i))) begin
        grant_oh[i] = 1'b1;
        sel_data    = bus.req_data[i*OPW +: OPW];
        sel_op      = bus.req_op[i];
      end
    end
  end

  assign slot_free     = (state_q == ST_IDLE) || bus.rsp_ready;
  assign accept        = grant_any && slot_free;
  assign bus.req_ready = grant_oh & {NUM_REQ{slot_free}};

  reduce4_unit #(.OPW(OPW)) u_reduce (
    .data   (sel_data),
    .op     (sel_op),
    .result (unit_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_FULL;
      ST_FULL: if (bus.rsp_ready && !accept) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.rsp_valid = (state_q == ST_FULL);
  end

  // Response slot, pointer and counter move only on an accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_id_q     <= '0;
      rsp_op_q     <= 1'b0;
      rsp_result_q <= 1'b0;
      rr_ptr_q     <= IDW'(NUM_REQ - 1);
      txn_q        <= '0;
    end else if (accept) begin
      rsp_id_q     <= grant_idx;
      rsp_op_q     <= sel_op;
      rsp_result_q <= unit_result;
      rr_ptr_q     <= grant_idx;
      txn_q        <= txn_q + CNTW'(1);
    end
  end

  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_op     = rsp_op_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.txn_count  = txn_q;

endmodule

// File: tb/tb_reduce_sched.sv
// Bench for reduce_sched: hand-derived vector table, corner sequences, and random traffic
// checked against a transaction-level model of the arbiter and response slot.
module tb_reduce_sched;

  localparam int N    = 4;
  localparam int IDW  = 2;
  localparam int OPW  = 4;
  localparam int CNTW = 8;

  logic clk;
  logic rst_n;

  reduce_sched_if #(.NUM_REQ(N), .IDW(IDW), .OPW(OPW), .CNTW(CNTW)) bus ();

  reduce_sched #(.NUM_REQ(N), .IDW(IDW), .OPW(OPW), .CNTW(CNTW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model state: last served requester, slot contents, accepted-request count.
  int m_last;
  bit m_full;
  int m_id;
  bit m_op;
  bit m_res;
  int m_cnt;

  typedef struct {
    logic [3:0]  vld;
    logic [3:0]  op;
    logic [15:0] data;
    logic        rr;
    logic [3:0]  exp_rdy;
    logic        exp_vld;
    logic [1:0]  exp_id;
    logic        exp_op;
    logic        exp_res;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t tbl [8];
  int   rot_exp [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_last = N - 1;
    m_full = 1'b0;
    m_id   = 0;
    m_op   = 1'b0;
    m_res  = 1'b0;
    m_cnt  = 0;
  endtask

  function automatic int model_grant();
    int g;
    g = -1;
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (m_last + k) % N;
      if (g < 0 && bus.req_valid[idx]) g = idx;
    end
    return g;
  endfunction

  // Check one cycle against the model at the falling edge, then advance the model at the rising edge.
  task automatic cycle();
    int         g;
    logic [3:0] exp_rdy;
    logic [3:0] d;
    @(negedge clk);
    g       = model_grant();
    exp_rdy = 4'b0000;
    if (g >= 0 && (!m_full || bus.rsp_ready)) exp_rdy = 4'(1 << g);
    chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_full));
    if (m_full) begin
      chk("rsp_id", 32'(bus.rsp_id), 32'(m_id));
      chk("rsp_op", 32'(bus.rsp_op), 32'(m_op));
      chk("rsp_result", 32'(bus.rsp_result), 32'(m_res));
    end
    chk("txn_count", 32'(bus.txn_count), 32'(m_cnt));
    @(posedge clk);
    if (exp_rdy != 4'b0000) begin
      d      = 4'(bus.req_data >> (g * OPW));
      m_full = 1'b1;
      m_id   = g;
      m_op   = bus.req_op[g];
      m_res  = m_op ? (d != 4'h0) : (d == 4'hF);
      m_last = g;
      m_cnt  = (m_cnt + 1) % 256;
    end else if (m_full && bus.rsp_ready) begin
      m_full = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_txn_count", 32'(bus.txn_count), 32'd0);
    chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    chk("rst_rsp_fields", {30'd0, bus.rsp_op, bus.rsp_result}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] o, input logic [15:0] d, input logic r);
    bus.req_valid = v;
    bus.req_op    = o;
    bus.req_data  = d;
    bus.rsp_ready = r;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{4'b0001, 4'b0000, 16'h000F, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b0, 1'b1, 8'd1};
    tbl[1] = '{4'b0100, 4'b0100, 16'h0400, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1, 1'b1, 8'd2};
    tbl[2] = '{4'b0100, 4'b0100, 16'h0000, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1, 1'b0, 8'd3};
    tbl[3] = '{4'b1111, 4'b0000, 16'hFFFF, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b0, 1'b1, 8'd4};
    tbl[4] = '{4'b1111, 4'b0001, 16'hFFF0, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1, 1'b0, 8'd5};
    tbl[5] = '{4'b0000, 4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 8'd5};
    tbl[6] = '{4'b0010, 4'b0000, 16'h00F0, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b0, 1'b1, 8'd6};
    tbl[7] = '{4'b1111, 4'b0000, 16'h0000, 1'b0, 4'b0000, 1'b1, 2'd1, 1'b0, 1'b1, 8'd6};
    rot_exp = '{0, 1, 2, 3, 0, 1};

    drive(4'b0000, 4'b0000, 16'h0000, 1'b1);
    do_reset();

    // Vector table: ready in the same cycle, response fields after the edge.
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].vld, tbl[i].op, tbl[i].data, tbl[i].rr);
      #1;
      chk("tbl_ready", 32'(bus.req_ready), 32'(tbl[i].exp_rdy));
      cycle();
      chk("tbl_rsp_valid", 32'(bus.rsp_valid), 32'(tbl[i].exp_vld));
      chk("tbl_txn_count", 32'(bus.txn_count), 32'(tbl[i].exp_cnt));
      if (tbl[i].exp_vld) begin
        chk("tbl_rsp_id", 32'(bus.rsp_id), 32'(tbl[i].exp_id));
        chk("tbl_rsp_op", 32'(bus.rsp_op), 32'(tbl[i].exp_op));
        chk("tbl_rsp_result", 32'(bus.rsp_result), 32'(tbl[i].exp_res));
      end
    end

    // Strict rotation with every requester valid.
    do_reset();
    for (int j = 0; j < 6; j++) begin
      drive(4'b1111, 4'($urandom), 16'($urandom), 1'b1);
      #1;
      chk("rot_grant", 32'(bus.req_ready), 32'(1 << rot_exp[j]));
      cycle();
    end

    // Blocked slot for five cycles, then the grant resumes at rr_ptr+1.
    for (int j = 0; j < 5; j++) begin
      drive(4'b1111, 4'($urandom), 16'($urandom), 1'b0);
      #1;
      chk("bp_ready", 32'(bus.req_ready), 32'd0);
      cycle();
    end
    drive(4'b1111, 4'b0000, 16'h0000, 1'b1);
    #1;
    chk("bp_resume", 32'(bus.req_ready), 32'b0100);
    cycle();

    // Counter wrap at 2^CNTW accepts.
    do_reset();
    drive(4'b0001, 4'b0000, 16'h0000, 1'b1);
    for (int n = 1; n <= 257; n++) begin
      cycle();
      if (n == 256) chk("wrap_256", 32'(bus.txn_count), 32'd0);
      if (n == 257) chk("wrap_257", 32'(bus.txn_count), 32'd1);
    end

    // Asynchronous reset while the slot is full, then priority back to requester 0.
    drive(4'b0001, 4'b0000, 16'h000F, 1'b0);
    cycle();
    #2;
    chk("pre_rst_valid", 32'(bus.rsp_valid), 32'd1);
    do_reset();
    drive(4'b1111, 4'b0000, 16'hFFFF, 1'b1);
    #1;
    chk("post_rst_grant", 32'(bus.req_ready), 32'b0001);
    cycle();

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      drive(4'($urandom), 4'($urandom), 16'($urandom), ($urandom_range(0, 3) != 0));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
